// File: rtl/spi_cmd_bridge.sv
// spi_cmd_bridge: drains command words from a FIFO, shifts one SPI frame per word to a selected slave
// with runtime CPOL/CPHA, and optionally pushes the captured MISO word to an output FIFO.
module spi_cmd_bridge #(
  parameter int DATA_W  = 32,
  parameter int SPI_W   = 16,
  parameter int NUM_CS  = 4,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        spi_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_empty,
  output logic              in_ren,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wen,
  input  logic              out_full,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [1:0]        err
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int HW = $clog2(2 * SPI_W + 1);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SETUP, SHIFT, HOLD, PUSH, GAP} state_t;
  state_t state, state_nx;
  logic [DW-1:0] div_cnt;
  logic [HW-1:0] half_cnt;
  logic [SPI_W-1:0] tx, rx;
  logic [5:0] cs_idx;
  logic rd, cpha, div_last, last_half, cs_bad, sck_edge, lead, unused;
  assign div_last  = div_cnt == DW'(CLK_DIV - 1);
  assign last_half = half_cnt == HW'(2 * SPI_W - 1);
  assign cs_bad    = 32'(in_data[DATA_W-3:DATA_W-8]) >= NUM_CS;
  // one SCK toggle per half period: the first on leaving SETUP, none after the final half
  assign sck_edge  = div_last && (state == SETUP || (state == SHIFT && !last_half));
  assign lead      = state == SETUP || half_cnt[0];
  assign unused    = ^in_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = en && !in_empty ? FETCH : IDLE;
      FETCH:   state_nx = LOAD;
      LOAD:    state_nx = cs_bad ? GAP : SETUP;
      SETUP:   state_nx = div_last ? SHIFT : SETUP;
      SHIFT:   state_nx = div_last && last_half ? HOLD : SHIFT;
      HOLD:    state_nx = div_last ? PUSH : HOLD;
      PUSH:    state_nx = GAP;
      GAP:     state_nx = div_last ? IDLE : GAP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ren   = state == FETCH;
    out_wen  = state == PUSH && rd && !out_full;
    busy     = state != IDLE;
    spi_cs_n = state inside {SETUP, SHIFT, HOLD} ? ~(NUM_CS'(1) << cs_idx) : '1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_cnt   <= '0;
      half_cnt  <= '0;
      tx        <= '0;
      rx        <= '0;
      cs_idx    <= '0;
      rd        <= 1'b0;
      cpha      <= 1'b0;
      spi_sck   <= 1'b0;
      spi_mosi  <= 1'b0;
      out_data  <= '0;
      frame_cnt <= '0;
      err       <= '0;
    end else begin
      div_cnt <= state inside {SETUP, SHIFT, HOLD, GAP} && !div_last ? div_cnt + 1'b1 : '0;
      if (state == SETUP) half_cnt <= '0;
      else if (state == SHIFT && div_last) half_cnt <= half_cnt + 1'b1;
      if (state == LOAD) begin
        rd     <= in_data[DATA_W-1];
        cs_idx <= in_data[DATA_W-3:DATA_W-8];
        cpha   <= spi_mode[0];
        if (cs_bad) err[1] <= 1'b1;
        else begin
          spi_sck  <= spi_mode[1];
          spi_mosi <= in_data[SPI_W-1];
          tx       <= spi_mode[0] ? in_data[SPI_W-1:0] : in_data[SPI_W-1:0] << 1;
        end
      end
      if (sck_edge) spi_sck <= ~spi_sck;
      // CPHA=0 samples on leading and drives on trailing; CPHA=1 the reverse
      if (sck_edge && !(lead ^ cpha)) begin
        spi_mosi <= tx[SPI_W-1];
        tx       <= tx << 1;
      end
      if (sck_edge && (lead ^ cpha)) rx <= SPI_W'({rx, spi_miso});
      if (state == HOLD && div_last) begin
        frame_cnt <= frame_cnt + 1'b1;
        if (rd) out_data <= DATA_W'(rx);
      end
      if (state == PUSH && rd && out_full) err[0] <= 1'b1;
    end
endmodule

// File: tb/tb_spi_cmd_bridge.sv
// tb_spi_cmd_bridge: FIFO and SPI-bus models around spi_cmd_bridge, checking frames against payload-level expectations.
module tb_spi_cmd_bridge;
  localparam int DATA_W = 32, SPI_W = 16, NUM_CS = 4, CLK_DIV = 4;
  localparam int CS_CYC = 2 * CLK_DIV * SPI_W + 2 * CLK_DIV;
  logic clk = 0, rst = 1, en = 0, out_full = 0;
  logic [1:0] spi_mode = 0;
  logic [DATA_W-1:0] in_data = '0;
  logic in_empty, in_ren, out_wen, spi_sck, spi_mosi, spi_miso, busy;
  logic [DATA_W-1:0] out_data;
  logic [NUM_CS-1:0] spi_cs_n;
  logic [15:0] frame_cnt;
  logic [1:0] err;
  spi_cmd_bridge #(.DATA_W(DATA_W), .SPI_W(SPI_W), .NUM_CS(NUM_CS), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .spi_mode(spi_mode), .in_data(in_data), .in_empty(in_empty),
    .in_ren(in_ren), .out_data(out_data), .out_wen(out_wen), .out_full(out_full), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n), .busy(busy), .frame_cnt(frame_cnt), .err(err)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0, exp_fc = 0;
  logic [1:0] exp_err = 0;
  logic [31:0] inq[$], outq[$];
  int in_level = 0, ren_cnt = 0, ren_empty = 0, wen_cnt = 0, sck_toggles = 0;
  logic [1:0] miso_sel = 0, mon_mode = 0;
  assign in_empty = in_level == 0;
  assign spi_miso = miso_sel[1] ? miso_sel[0] : spi_mosi;
  always @(negedge clk) begin
    if (in_ren) begin
      ren_cnt++;
      if (in_level == 0) ren_empty++;
      else begin
        in_data = inq.pop_front();
        in_level--;
      end
    end
    if (out_wen) begin
      outq.push_back(out_data);
      wen_cnt++;
    end
  end
  typedef struct packed {logic [15:0] mosi; logic [7:0] edges; logic [15:0] cyc; logic [3:0] cs;} frame_t;
  frame_t frq[$];
  frame_t cur;
  logic prev_sck = 0, prev_act = 0;
  always @(negedge clk) begin
    if (rst) begin
      cur = {16'h0, 8'd0, 16'd0, 4'hf};
      prev_act = 0;
    end else begin
      if (spi_sck !== prev_sck) begin
        sck_toggles++;
        if (prev_act && spi_cs_n != 4'hf) begin
          cur.edges = cur.edges + 1;
          if ((spi_sck != mon_mode[1]) ^ mon_mode[0]) cur.mosi = {cur.mosi[14:0], spi_mosi};
        end
      end
      if (spi_cs_n != 4'hf) begin
        cur.cyc = cur.cyc + 1;
        cur.cs = spi_cs_n;
      end else if (prev_act) begin
        frq.push_back(cur);
        cur = {16'h0, 8'd0, 16'd0, 4'hf};
      end
      prev_act = spi_cs_n != 4'hf;
    end
    prev_sck = spi_sck;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push_word(input logic [31:0] w);
    inq.push_back(w);
    in_level++;
  endtask
  task automatic wait_done();
    int n = 0;
    while ((busy || in_level != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL wait_done: still busy=%b level=%0d after %0d cycles, required idle", busy, in_level, n);
    end
  endtask
  function automatic logic [31:0] mk(input logic rd, input logic [5:0] cs, input logic [15:0] p);
    logic res = 1'($urandom);
    logic [7:0] junk = 8'($urandom);
    return {rd, res, cs, junk, p};
  endfunction
  task automatic test_reset();
    rst = 1;
    tick(3);
    checks++;
    if ({in_ren, out_wen, busy, spi_sck, spi_mosi} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000", {in_ren, out_wen, busy, spi_sck, spi_mosi});
    end
    checks++;
    if (spi_cs_n !== 4'hf) begin errors++; $display("FAIL reset_cs: got %b required 1111", spi_cs_n); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h required 0", out_data); end
    checks++;
    if ({frame_cnt, err} !== 18'h0) begin errors++; $display("FAIL reset_cnt: got %h/%b required 0/00", frame_cnt, err); end
    rst = 0;
    en = 1;
    tick(3);
    checks++;
    if (busy !== 1'b0 || in_ren !== 1'b0) begin errors++; $display("FAIL empty_idle: busy=%b ren=%b required 0/0", busy, in_ren); end
  endtask
  task automatic test_single();
    int f0 = frq.size(), w0 = wen_cnt;
    spi_mode = 2'b00; mon_mode = 2'b00; miso_sel = 2'b10;
    push_word(32'h0000_A5C3);
    wait_done();
    exp_fc++;
    checks++;
    if (frq.size() != f0 + 1) begin errors++; $display("FAIL t1_count: got %0d frames required 1", frq.size() - f0); end
    else if (frq[f0] !== {16'hA5C3, 8'd32, 16'(CS_CYC), 4'b1110}) begin
      errors++; $display("FAIL t1_frame: got %h required %h", frq[f0], {16'hA5C3, 8'd32, 16'(CS_CYC), 4'b1110});
    end
    checks++;
    if (wen_cnt != w0 || frame_cnt !== 16'(exp_fc)) begin
      errors++; $display("FAIL t1_status: wen=%0d frame_cnt=%0d required 0/%0d", wen_cnt - w0, frame_cnt, exp_fc);
    end
  endtask
  task automatic test_loopback_rd();
    int f0 = frq.size(), w0 = wen_cnt, o0 = outq.size();
    spi_mode = 2'b11; mon_mode = 2'b11; miso_sel = 2'b00;
    push_word(32'h8100_1234);
    wait_done();
    exp_fc++;
    checks++;
    if (frq.size() != f0 + 1) begin errors++; $display("FAIL t2_count: got %0d frames required 1", frq.size() - f0); end
    else if (frq[f0] !== {16'h1234, 8'd32, 16'(CS_CYC), 4'b1101}) begin
      errors++; $display("FAIL t2_frame: got %h required %h", frq[f0], {16'h1234, 8'd32, 16'(CS_CYC), 4'b1101});
    end
    checks++;
    if (spi_sck !== 1'b1) begin errors++; $display("FAIL t2_sck_idle: got %b required 1", spi_sck); end
    checks++;
    if (wen_cnt != w0 + 1 || outq.size() != o0 + 1) begin errors++; $display("FAIL t2_wen: got %0d pulses required 1", wen_cnt - w0); end
    else if (outq[o0] !== 32'h0000_1234) begin errors++; $display("FAIL t2_data: got %h required 00001234", outq[o0]); end
    checks++;
    if (frame_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL t2_fc: got %0d required %0d", frame_cnt, exp_fc); end
  endtask
  task automatic test_back_to_back();
    logic [15:0] pay[3];
    logic [5:0] cs[3];
    int f0, o0, r0;
    for (int mi = 0; mi < 2; mi++) begin
      spi_mode = mi == 0 ? 2'b01 : 2'b10; mon_mode = spi_mode; miso_sel = 2'b00;
      f0 = frq.size(); o0 = outq.size(); r0 = ren_cnt;
      for (int k = 0; k < 3; k++) begin
        pay[k] = 16'($urandom);
        cs[k] = 6'($urandom_range(0, NUM_CS - 1));
        push_word(mk(1'b1, cs[k], pay[k]));
      end
      wait_done();
      exp_fc += 3;
      checks++;
      if (ren_cnt != r0 + 3 || ren_empty != 0) begin errors++; $display("FAIL t3_ren: got %0d pulses (%0d empty) required 3", ren_cnt - r0, ren_empty); end
      checks++;
      if (frame_cnt !== 16'(exp_fc)) begin errors++; $display("FAIL t3_fc: got %0d required %0d", frame_cnt, exp_fc); end
      checks++;
      if (outq.size() != o0 + 3 || frq.size() != f0 + 3) begin
        errors++; $display("FAIL t3_count: got %0d pushes %0d frames required 3/3", outq.size() - o0, frq.size() - f0);
      end else
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (outq[o0+k] !== {16'h0, pay[k]}) begin errors++; $display("FAIL t3_data%0d: got %h required %h", k, outq[o0+k], {16'h0, pay[k]}); end
          checks++;
          if (frq[f0+k] !== {pay[k], 8'd32, 16'(CS_CYC), ~(4'b1 << cs[k])}) begin
            errors++; $display("FAIL t3_frame%0d: got %h required %h", k, frq[f0+k], {pay[k], 8'd32, 16'(CS_CYC), ~(4'b1 << cs[k])});
          end
        end
    end
  endtask
  task automatic test_errors();
    int f0 = frq.size(), w0 = wen_cnt, t0;
    spi_mode = 2'b00; mon_mode = 2'b00; miso_sel = 2'b11; out_full = 1;
    push_word(mk(1'b1, 6'd2, 16'h5A5A));
    wait_done();
    out_full = 0;
    exp_fc++;
    checks++;
    if (err !== 2'b01 || wen_cnt != w0) begin errors++; $display("FAIL t4_full: err=%b wen=%0d required 01/0", err, wen_cnt - w0); end
    checks++;
    if (frame_cnt !== 16'(exp_fc) || frq.size() != f0 + 1) begin
      errors++; $display("FAIL t4_full_frame: fc=%0d frames=%0d required %0d/1", frame_cnt, frq.size() - f0, exp_fc);
    end else if (frq[f0].edges !== 8'd32) begin errors++; $display("FAIL t4_full_edges: got %0d required 32", frq[f0].edges); end
    t0 = sck_toggles; f0 = frq.size();
    push_word(mk(1'b1, 6'd5, 16'hFFFF));
    wait_done();
    checks++;
    if (err !== 2'b11) begin errors++; $display("FAIL t4_badcs_err: got %b required 11", err); end
    checks++;
    if (sck_toggles != t0 || frq.size() != f0 || frame_cnt !== 16'(exp_fc)) begin
      errors++; $display("FAIL t4_badcs_bus: toggles=%0d frames=%0d fc=%0d required 0/0/%0d", sck_toggles - t0, frq.size() - f0, frame_cnt, exp_fc);
    end
  endtask
  task automatic test_reset_mid_frame();
    int t0 = sck_toggles, n = 0, f0;
    spi_mode = 2'b00; mon_mode = 2'b00; miso_sel = 2'b00;
    push_word(mk(1'b0, 6'd3, 16'hC0DE));
    while (sck_toggles < t0 + 7 && n < 2000) begin @(negedge clk); n++; end
    #2 rst = 1;
    #1;
    checks++;
    if (spi_cs_n !== 4'hf || spi_sck !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL t5_abort: cs_n=%b sck=%b busy=%b required 1111/0/0 (toggles seen %0d)", spi_cs_n, spi_sck, busy, sck_toggles - t0);
    end
    @(negedge clk);
    #1 rst = 0;
    exp_fc = 0; exp_err = 0;
    checks++;
    if (frame_cnt !== 16'h0 || err !== 2'b00) begin errors++; $display("FAIL t5_clear: fc=%0d err=%b required 0/00", frame_cnt, err); end
    @(negedge clk);
    f0 = frq.size();
    push_word(mk(1'b0, 6'd0, 16'h0F0F));
    wait_done();
    exp_fc++;
    checks++;
    if (frame_cnt !== 16'(exp_fc) || frq.size() != f0 + 1) begin errors++; $display("FAIL t5_after: fc=%0d frames=%0d required 1/1", frame_cnt, frq.size() - f0); end
    else if (frq[f0] !== {16'h0F0F, 8'd32, 16'(CS_CYC), 4'b1110}) begin
      errors++; $display("FAIL t5_frame: got %h required %h", frq[f0], {16'h0F0F, 8'd32, 16'(CS_CYC), 4'b1110});
    end
  endtask
  task automatic test_en_drop();
    int t0 = sck_toggles, n = 0, r0 = ren_cnt;
    spi_mode = 2'b00; mon_mode = 2'b00;
    push_word(mk(1'b0, 6'd1, 16'h1111));
    push_word(mk(1'b0, 6'd2, 16'h2222));
    while (sck_toggles < t0 + 6 && n < 2000) begin @(negedge clk); n++; end
    en = 0;
    n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    tick(40);
    exp_fc++;
    checks++;
    if (frame_cnt !== 16'(exp_fc) || in_level != 1 || ren_cnt != r0 + 1 || busy !== 1'b0) begin
      errors++; $display("FAIL t6_hold: fc=%0d level=%0d ren=%0d busy=%b required %0d/1/1/0", frame_cnt, in_level, ren_cnt - r0, busy, exp_fc);
    end
    en = 1;
    wait_done();
    exp_fc++;
    checks++;
    if (frame_cnt !== 16'(exp_fc) || ren_cnt != r0 + 2) begin errors++; $display("FAIL t6_resume: fc=%0d ren=%0d required %0d/2", frame_cnt, ren_cnt - r0, exp_fc); end
  endtask
  task automatic test_random();
    logic [1:0] m, sel;
    logic [5:0] cs;
    logic [15:0] p, rx;
    logic rd, full;
    int f0, o0;
    for (int i = 0; i < 12; i++) begin
      m = 2'($urandom); cs = 6'($urandom_range(0, 5)); rd = 1'($urandom); p = 16'($urandom);
      full = $urandom_range(0, 3) == 0;
      sel = $urandom_range(0, 2) == 0 ? 2'b00 : {1'b1, 1'($urandom)};
      rx = sel[1] ? {16{sel[0]}} : p;
      spi_mode = m; mon_mode = m; miso_sel = sel; out_full = full;
      f0 = frq.size(); o0 = outq.size();
      push_word(mk(rd, cs, p));
      tick(4);
      spi_mode = 2'($urandom);
      wait_done();
      if (cs >= NUM_CS) exp_err[1] = 1'b1;
      else begin
        exp_fc++;
        if (rd && full) exp_err[0] = 1'b1;
      end
      checks++;
      if (err !== exp_err || frame_cnt !== 16'(exp_fc)) begin
        errors++; $display("FAIL rnd%0d_status: err=%b fc=%0d required %b/%0d", i, err, frame_cnt, exp_err, exp_fc);
      end
      checks++;
      if (frq.size() != f0 + (cs < NUM_CS ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_count: got %0d frames", i, frq.size() - f0); end
      else if (cs < NUM_CS && frq[f0] !== {p, 8'd32, 16'(CS_CYC), ~(4'b1 << cs)}) begin
        errors++; $display("FAIL rnd%0d_frame: got %h required %h", i, frq[f0], {p, 8'd32, 16'(CS_CYC), ~(4'b1 << cs)});
      end
      checks++;
      if (outq.size() != o0 + (rd && !full && cs < NUM_CS ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_push: got %0d pushes", i, outq.size() - o0); end
      else if (outq.size() > o0 && outq[o0] !== {16'h0, rx}) begin errors++; $display("FAIL rnd%0d_data: got %h required %h", i, outq[o0], {16'h0, rx}); end
    end
    out_full = 0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_loopback_rd();
    test_back_to_back();
    test_errors();
    test_reset_mid_frame();
    test_en_drop();
    test_random();
    checks++;
    if (ren_empty != 0) begin errors++; $display("FAIL ren_empty: got %0d reads while empty required 0", ren_empty); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
